// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the keypad digit-entry block.
//   BCD_W        - width of one BCD digit slot
//   DIGIT_MAX    - largest keypad code that is a decimal digit
//   conv_state_e - state encoding of the serial BCD-to-binary converter
package calc_pkg;

  localparam int BCD_W     = 4;
  localparam int DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bcd_to_bin_serial.sv
// bcd_to_bin_serial: serial BCD-to-binary converter, one digit per clock.
//   clk      - clock, rising edge
//   reset    - asynchronous, active-low
//   start_i  - (re)start a conversion from the top slot with acc = 0
//   abort_i  - drop any running conversion, return to IDLE
//   digits_i - BCD digit slots, slot 0 least significant
//   busy_o   - conversion in progress (CONV state)
//   done_o   - high in the cycle whose clock edge loads value_o
//   value_o  - last completed binary result
module bcd_to_bin_serial
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [BCD_W*DIGITS-1:0]   digits_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [VALUE_W-1:0]        value_o
);

  localparam int IDX_W = $clog2(DIGITS);

  conv_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [VALUE_W-1:0]   acc_q, acc_d;
  logic [VALUE_W-1:0]   value_q, value_d;

  logic [BCD_W-1:0]     slot;
  logic [VALUE_W+3:0]   acc_x10;
  logic [VALUE_W-1:0]   acc_nxt;

  assign slot = digits_i[idx_q*BCD_W +: BCD_W];

  // x10 as x8 + x2 with 4 bits of headroom, then truncated
  assign acc_x10 = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1);
  assign acc_nxt = acc_x10[VALUE_W-1:0] + VALUE_W'(slot);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    value_d = value_q;
    done_o  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      // a start in any state, including mid-CONV, restarts from the top slot
      state_d = CONV;
      idx_d   = IDX_W'(DIGITS - 1);
      acc_d   = '0;
    end else begin
      unique case (state_q)
        CONV: begin
          acc_d = acc_nxt;
          if (idx_q == '0) begin
            state_d = DONE;
            value_d = acc_nxt;
            done_o  = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      value_q <= value_d;
    end
  end

  assign busy_o  = (state_q == CONV);
  assign value_o = value_q;

endmodule

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: keypad digit-entry buffer with serial binary conversion.
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low
//   num        - keypad code (0..9 digits, 10..15 non-digits)
//   numPressed - key-held level
//   backspace  - delete-key level
//   erase      - clear-key level
//   digits     - BCD buffer, slot 0 (bits 3:0) rightmost
//   count      - significant digits entered
//   full       - count == DIGITS
//   reject     - one-cycle pulse on an ignored keystroke
//   busy       - conversion running
//   valid      - value matches digits
//   value      - binary equivalent of digits
module digit_entry_buffer
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   num,
  input  logic                         numPressed,
  input  logic                         backspace,
  input  logic                         erase,
  output logic [BCD_W*DIGITS-1:0]      digits,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic                         reject,
  output logic                         busy,
  output logic                         valid,
  output logic [VALUE_W-1:0]           value
);

  localparam int CNT_W = $clog2(DIGITS+1);

  logic np_q, bs_q, er_q;
  // Low for the first clock after reset so keys held across release
  // are only registered, never treated as edges.
  logic armed_q;

  logic [DIGITS-1:0][BCD_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         reject_q, reject_d;
  logic                         valid_q, valid_d;
  logic                         start_q;
  logic                         change;
  logic                         np_edge, bs_edge, er_edge;
  logic                         full_w;
  logic                         conv_done;

  assign np_edge = numPressed & ~np_q & armed_q;
  assign bs_edge = backspace  & ~bs_q & armed_q;
  assign er_edge = erase      & ~er_q & armed_q;
  assign full_w  = (count_q == CNT_W'(DIGITS));

  // erase > backspace > digit; losers in the same cycle vanish silently
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    reject_d = 1'b0;
    change   = 1'b0;
    if (er_edge) begin
      digits_d = '0;
      count_d  = '0;
      change   = 1'b1;
    end else if (bs_edge) begin
      if (count_q == '0) begin
        reject_d = 1'b1;
      end else begin
        digits_d = {BCD_W'(0), digits_q[DIGITS-1:1]};
        count_d  = count_q - CNT_W'(1);
        change   = 1'b1;
      end
    end else if (np_edge) begin
      if (num > 4'(DIGIT_MAX) || full_w) begin
        reject_d = 1'b1;
      end else if (!(num == 4'd0 && count_q == '0)) begin
        digits_d = {digits_q[DIGITS-2:0], num};
        count_d  = count_q + CNT_W'(1);
        change   = 1'b1;
      end
    end
  end

  // A buffer change in the same cycle as a finishing conversion wins:
  // the result just loaded belongs to the old contents.
  always_comb begin
    valid_d = valid_q;
    if (change)         valid_d = 1'b0;
    else if (conv_done) valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      np_q     <= 1'b0;
      bs_q     <= 1'b0;
      er_q     <= 1'b0;
      armed_q  <= 1'b0;
      digits_q <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
      valid_q  <= 1'b1;
      start_q  <= 1'b0;
    end else begin
      np_q     <= numPressed;
      bs_q     <= backspace;
      er_q     <= erase;
      armed_q  <= 1'b1;
      digits_q <= digits_d;
      count_q  <= count_d;
      reject_q <= reject_d;
      valid_q  <= valid_d;
      start_q  <= change;
    end
  end

  bcd_to_bin_serial #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_q),
    .abort_i  (er_edge),
    .digits_i (digits_q),
    .busy_o   (busy),
    .done_o   (conv_done),
    .value_o  (value)
  );

  assign digits = digits_q;
  assign count  = count_q;
  assign full   = full_w;
  assign reject = reject_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
module tb_digit_entry_buffer;

  localparam int K_DIG    = 0;
  localparam int K_BS     = 1;
  localparam int K_ER     = 2;
  localparam int K_ER_DIG = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  num;
  logic        numPressed, backspace, erase;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        full, reject, busy, valid;
  logic [13:0] value;

  int n_checks = 0;
  int n_fail   = 0;

  int md[4];
  int mc;
  int sb[$];
  logic vprev = 1'b1;

  always #5 clk = ~clk;

  digit_entry_buffer #(.DIGITS(4), .VALUE_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .num        (num),
    .numPressed (numPressed),
    .backspace  (backspace),
    .erase      (erase),
    .digits     (digits),
    .count      (count),
    .full       (full),
    .reject     (reject),
    .busy       (busy),
    .valid      (valid),
    .value      (value)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [15:0] mpack();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(md[i]);
    return r;
  endfunction

  function automatic int mval();
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + md[i];
    return v;
  endfunction

  task automatic mclear();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mc = 0;
  endtask

  // Scoreboard consumer: every rising valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      vprev = 1'b1;
    end else begin
      if (valid && !vprev) begin
        if (sb.size() == 0) check_eq("spurious_valid", 32'(valid), 32'd0);
        else                check_eq("value", 32'(value), 32'(sb.pop_front()));
      end
      vprev = valid;
    end
  end

  // One-cycle keystroke; model updated alongside, reject/buffer checked after the edge.
  task automatic key(input int kind, input logic [3:0] n);
    logic rej;
    rej = 1'b0;
    @(negedge clk);
    num = n;
    case (kind)
      K_DIG: begin
        numPressed = 1'b1;
        if (n > 9 || mc == 4) rej = 1'b1;
        else if (!(n == 0 && mc == 0)) begin
          for (int i = 3; i > 0; i--) md[i] = md[i-1];
          md[0] = int'(n);
          mc++;
        end
      end
      K_BS: begin
        backspace = 1'b1;
        if (mc == 0) rej = 1'b1;
        else begin
          for (int i = 0; i < 3; i++) md[i] = md[i+1];
          md[3] = 0;
          mc--;
        end
      end
      K_ER: begin
        erase = 1'b1;
        mclear();
      end
      default: begin
        erase = 1'b1;
        numPressed = 1'b1;
        mclear();
      end
    endcase
    @(negedge clk);
    check_eq("reject", 32'(reject), 32'(rej));
    check_eq("digits", 32'(digits), 32'(mpack()));
    check_eq("count",  32'(count),  32'(mc));
    numPressed = 1'b0;
    backspace  = 1'b0;
    erase      = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check_eq("conv_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic settle();
    sb.push_back(mval());
    wait_empty();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_digits"}, 32'(digits), 32'd0);
    check_eq({tag, "_count"},  32'(count),  32'd0);
    check_eq({tag, "_full"},   32'(full),   32'd0);
    check_eq({tag, "_reject"}, 32'(reject), 32'd0);
    check_eq({tag, "_busy"},   32'(busy),   32'd0);
    check_eq({tag, "_value"},  32'(value),  32'd0);
    check_eq({tag, "_valid"},  32'(valid),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; num = 4'd0; numPressed = 1'b0; backspace = 1'b0; erase = 1'b0;
    mclear();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1,2,3 -> 123, with fixed latency
    key(K_DIG, 4'd1); key(K_DIG, 4'd2); key(K_DIG, 4'd3);
    sb.push_back(mval());
    repeat (4) @(negedge clk);
    check_eq("lat_valid_lo", 32'(valid), 32'd0);
    @(negedge clk);
    check_eq("lat_valid_hi", 32'(valid), 32'd1);
    check_eq("lat_value",    32'(value), 32'd123);
    wait_empty();

    // fill to 9999, fifth digit rejected
    key(K_ER, 4'd0); settle();
    for (int i = 0; i < 4; i++) key(K_DIG, 4'd9);
    key(K_DIG, 4'd5);
    settle();
    check_eq("full", 32'(full), 32'd1);
    check_eq("value_9999", 32'(value), 32'd9999);

    // leading zeros suppressed, non-digit rejected
    key(K_ER, 4'd0); settle();
    key(K_DIG, 4'd0); key(K_DIG, 4'd0); key(K_DIG, 4'd7);
    key(K_DIG, 4'd12);
    settle();

    // backspace down to empty, last one rejected
    key(K_ER, 4'd0); settle();
    key(K_DIG, 4'd4); key(K_DIG, 4'd5); key(K_DIG, 4'd6); settle();
    key(K_BS, 4'd0); settle();
    key(K_BS, 4'd0); key(K_BS, 4'd0); key(K_BS, 4'd0);
    settle();

    // digit entered mid-conversion restarts it
    key(K_ER, 4'd0); settle();
    key(K_DIG, 4'd1); key(K_DIG, 4'd2);
    repeat (2) @(negedge clk);
    check_eq("busy_mid", 32'(busy), 32'd1);
    key(K_DIG, 4'd8);
    repeat (4) @(negedge clk);
    check_eq("restart_valid_lo", 32'(valid), 32'd0);
    settle();
    check_eq("value_128", 32'(value), 32'd128);

    // erase beats a simultaneous digit
    key(K_ER_DIG, 4'd5); settle();

    // reset mid-conversion, key held across release
    key(K_DIG, 4'd3);
    @(negedge clk);
    check_eq("busy_pre_rst", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    num = 4'd3;
    numPressed = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mclear();
    repeat (3) @(negedge clk);
    check_eq("held_count",  32'(count),  32'd0);
    check_eq("held_digits", 32'(digits), 32'd0);
    check_eq("held_busy",   32'(busy),   32'd0);
    check_eq("held_valid",  32'(valid),  32'd1);
    numPressed = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
